sha256_msg_padder: RTL and testbench

Upstream message-formatting stage of the SHA-256 core. It accepts a byte-aligned message as a stream of 32-bit big-endian words and emits the padded stream as 512-bit blocks, one 32-bit word per beat. Padding follows FIPS 180-4: a 0x80 byte, zero fill, then the 64-bit bit length. It also produces the final 64-bit message bit length and a one-cycle load strobe that drives the 64-bit length register's `start`/`data_i` directly downstream.

---
 rtl/sha256_msg_padder_if.sv | 36 +++
 rtl/sha256_msg_padder.sv | 162 ++++++++++++++++
 tb/tb_sha256_msg_padder.sv | 225 ++++++++++++++++++++++
 3 files changed

// File: rtl/sha256_msg_padder_if.sv
// Stream bundle for the SHA-256 message padder: the byte-aligned input word
// stream, the padded 32-bit output stream and the message length strobe.
interface sha256_msg_padder_if;
  // Input message stream
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic        in_last;
  logic [2:0]  in_bytes;

  // Padded output stream
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic [3:0]  out_word_idx;
  logic        out_block_last;
  logic        out_msg_last;

  // Final message length, handed to the length register
  logic [63:0] len_o;
  logic        len_valid;

  // Padder side
  modport slave (
    input  in_valid, in_data, in_last, in_bytes, out_ready,
    output in_ready, out_valid, out_data, out_word_idx, out_block_last,
           out_msg_last, len_o, len_valid
  );

  // Producer / consumer side
  modport master (
    output in_valid, in_data, in_last, in_bytes, out_ready,
    input  in_ready, out_valid, out_data, out_word_idx, out_block_last,
           out_msg_last, len_o, len_valid
  );
endinterface

// File: rtl/sha256_msg_padder.sv
// SHA-256 message padder. Passes message words through, then appends the
// 0x80 marker, zero fill and the 64-bit big-endian bit length so that the
// stream forms whole 512-bit blocks. The output stage is a single register
// that reloads whenever it is empty or being drained.
module sha256_msg_padder (
  input  logic                CLK,
  input  logic                RST,
  sha256_msg_padder_if.slave  bus
);

  typedef enum logic [2:0] {
    MSG,    // passing message words through
    PAD80,  // message ended on a word boundary: emit the 0x80000000 word
    ZERO,   // zero fill up to word index 13
    LENHI,  // length high word, always at index 14
    LENLO   // length low word, always at index 15
  } state_t;

  state_t      state_q, state_d;
  logic [60:0] byte_cnt_q, byte_cnt_d;    // bytes accepted in this message
  logic [3:0]  idx_q, idx_d;              // index given to the next loaded word
  logic        out_valid_q, out_valid_d;
  logic [31:0] out_data_q, out_data_d;
  logic [3:0]  out_word_idx_q, out_word_idx_d;
  logic        out_msg_last_q, out_msg_last_d;
  logic [63:0] len_q, len_d;
  logic        len_valid_q, len_valid_d;

  logic        adv;        // output register can take a new word this cycle
  logic        in_ready;
  logic        accept;     // input word transferred this cycle
  logic [2:0]  k;          // valid bytes of the last word, normalised to 1..4
  logic        load;
  logic [31:0] load_data;

  assign adv      = !out_valid_q || bus.out_ready;
  assign in_ready = (state_q == MSG) && adv && !RST;
  assign accept   = bus.in_valid && in_ready;
  assign k        = (bus.in_bytes == 3'd0 || bus.in_bytes > 3'd4) ? 3'd4 : bus.in_bytes;

  // Next-state, next-output and counter update logic
  always_comb begin
    // NOTE: every signal gets a default here so no path leaves one unassigned;
    // a missing default would infer a latch.
    state_d        = state_q;
    byte_cnt_d     = byte_cnt_q;
    idx_d          = idx_q;
    out_valid_d    = out_valid_q;
    out_data_d     = out_data_q;
    out_word_idx_d = out_word_idx_q;
    out_msg_last_d = out_msg_last_q;
    len_d          = len_q;
    len_valid_d    = 1'b0;
    load           = 1'b0;
    load_data      = 32'h0;

    unique case (state_q)
      MSG: begin
        if (accept) begin
          load      = 1'b1;
          load_data = bus.in_data;
          if (bus.in_last) begin
            len_valid_d = 1'b1;
            byte_cnt_d  = byte_cnt_q + {58'd0, k};
            len_d       = {byte_cnt_d, 3'b000};
            unique case (k)
              3'd1:    load_data = {bus.in_data[31:24], 8'h80, 16'h0000};
              3'd2:    load_data = {bus.in_data[31:16], 8'h80, 8'h00};
              3'd3:    load_data = {bus.in_data[31:8], 8'h80};
              default: load_data = bus.in_data;
            endcase
            // A partial last word already carries the 0x80 marker; if it sits
            // at index 13 the length follows directly, otherwise zero fill
            // (at 14/15 the fill wraps into a fresh block).
            if (k == 3'd4)           state_d = PAD80;
            else if (idx_q == 4'd13) state_d = LENHI;
            else                     state_d = ZERO;
          end else begin
            byte_cnt_d = byte_cnt_q + 61'd4;
          end
        end
      end
      PAD80: begin
        if (adv) begin
          load      = 1'b1;
          load_data = 32'h8000_0000;
          state_d   = (idx_q == 4'd13) ? LENHI : ZERO;
        end
      end
      ZERO: begin
        if (adv) begin
          load      = 1'b1;
          load_data = 32'h0000_0000;
          if (idx_q == 4'd13) state_d = LENHI;
        end
      end
      LENHI: begin
        if (adv) begin
          load      = 1'b1;
          load_data = len_q[63:32];
          state_d   = LENLO;
        end
      end
      LENLO: begin
        if (adv) begin
          load       = 1'b1;
          load_data  = len_q[31:0];
          byte_cnt_d = 61'd0;
          state_d    = MSG;
        end
      end
      default: state_d = MSG;
    endcase

    if (load) begin
      out_valid_d    = 1'b1;
      out_data_d     = load_data;
      out_word_idx_d = idx_q;
      out_msg_last_d = (state_q == LENLO);
      idx_d          = (state_q == LENLO) ? 4'd0 : idx_q + 4'd1;
    end else if (bus.out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  // State and output registers; reset discards any message in flight
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q        <= MSG;
      byte_cnt_q     <= '0;
      idx_q          <= '0;
      out_valid_q    <= 1'b0;
      out_data_q     <= '0;
      out_word_idx_q <= '0;
      out_msg_last_q <= 1'b0;
      len_q          <= '0;
      len_valid_q    <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the values
      // computed before this edge, independent of statement order.
      state_q        <= state_d;
      byte_cnt_q     <= byte_cnt_d;
      idx_q          <= idx_d;
      out_valid_q    <= out_valid_d;
      out_data_q     <= out_data_d;
      out_word_idx_q <= out_word_idx_d;
      out_msg_last_q <= out_msg_last_d;
      len_q          <= len_d;
      len_valid_q    <= len_valid_d;
    end
  end

  assign bus.in_ready       = in_ready;
  assign bus.out_valid      = out_valid_q;
  assign bus.out_data       = out_data_q;
  assign bus.out_word_idx   = out_word_idx_q;
  assign bus.out_block_last = (out_word_idx_q == 4'd15);
  assign bus.out_msg_last   = out_msg_last_q;
  assign bus.len_o          = len_q;
  assign bus.len_valid      = len_valid_q;

endmodule

// File: tb/tb_sha256_msg_padder.sv
// Randomized bench for sha256_msg_padder. A byte-level FIPS 180-4 padding
// model produces the expected output words and lengths for each message.
module tb_sha256_msg_padder;

  logic clk = 1'b0;
  logic rst = 1'b1;
  sha256_msg_padder_if bus_if ();

  sha256_msg_padder dut (.CLK(clk), .RST(rst), .bus(bus_if));

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] data;
    logic [3:0]  idx;
    logic        last;
  } exp_t;

  exp_t        exp_q[$];
  logic [63:0] len_q[$];
  logic [7:0]  msg[$];

  int n_checks = 0;
  int n_fail   = 0;
  bit mon_en   = 1'b0;
  bit bp_en    = 1'b0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Reference: message bytes, 0x80, zeros to 56 mod 64, 64-bit bit length.
  task automatic model_push();
    logic [7:0]  p[$];
    logic [63:0] bits;
    int          nw;
    p    = msg;
    bits = 64'(msg.size()) * 64'd8;
    p.push_back(8'h80);
    while (p.size() % 64 != 56) p.push_back(8'h00);
    for (int i = 7; i >= 0; i--) p.push_back(bits[8*i +: 8]);
    nw = p.size() / 4;
    for (int w = 0; w < nw; w++) begin
      exp_t e;
      e.data = {p[4*w], p[4*w+1], p[4*w+2], p[4*w+3]};
      e.idx  = 4'(w % 16);
      e.last = (w == nw - 1);
      exp_q.push_back(e);
    end
    len_q.push_back(bits);
  endtask

  task automatic send_word(input logic [31:0] data, input logic last, input logic [2:0] nb);
    bit done = 1'b0;
    @(negedge clk);
    bus_if.in_valid = 1'b1;
    bus_if.in_data  = data;
    bus_if.in_last  = last;
    bus_if.in_bytes = nb;
    for (int c = 0; c < 1000 && !done; c++) begin
      #4;
      if (bus_if.in_ready) begin
        @(posedge clk);
        done = 1'b1;
      end else begin
        @(negedge clk);
      end
    end
    if (!done) check("in_accept_timeout", 64'(done), 64'd1);
    #1 bus_if.in_valid = 1'b0;
  endtask

  task automatic send_msg();
    logic [2:0] opts [5] = '{3'd0, 3'd4, 3'd5, 3'd6, 3'd7};
    model_push();
    for (int i = 0; i < msg.size(); i += 4) begin
      int          kk;
      logic [31:0] d;
      logic        last;
      logic [2:0]  nb;
      kk   = (msg.size() - i >= 4) ? 4 : msg.size() - i;
      d    = $urandom;  // junk in unused bytes must be replaced by padding
      for (int j = 0; j < kk; j++) d[31-8*j -: 8] = msg[i+j];
      last = (i + 4 >= msg.size());
      if (!last)        nb = 3'($urandom_range(0, 7));
      else if (kk == 4) nb = opts[$urandom_range(0, 4)];
      else              nb = 3'(kk);
      if ($urandom_range(0, 3) == 0) @(negedge clk);
      send_word(d, last, nb);
    end
  endtask

  task automatic drain();
    for (int c = 0; c < 5000 && (exp_q.size() != 0 || len_q.size() != 0); c++) @(negedge clk);
    repeat (3) @(negedge clk);
    check("drain_out_words", 64'(exp_q.size()), 64'd0);
    check("drain_len", 64'(len_q.size()), 64'd0);
  endtask

  task automatic rand_msg(input int n);
    msg.delete();
    for (int i = 0; i < n; i++) msg.push_back(8'($urandom));
  endtask

  // Downstream ready: always high, or random when backpressure is enabled
  always @(negedge clk) bus_if.out_ready = bp_en ? 1'($urandom_range(0, 1)) : 1'b1;

  // Output monitor, sampled one time unit before each rising edge
  logic [31:0] prev_data;
  logic [3:0]  prev_idx;
  bit          prev_stall = 1'b0;
  initial begin
    forever begin
      @(negedge clk);
      #4;
      if (!mon_en) begin
        prev_stall = 1'b0;
      end else begin
        if (prev_stall) begin
          check("stall_valid", 64'(bus_if.out_valid), 64'd1);
          check("stall_data", 64'(bus_if.out_data), 64'(prev_data));
          check("stall_idx", 64'(bus_if.out_word_idx), 64'(prev_idx));
        end
        if (bus_if.out_valid && !bus_if.out_ready) begin
          check("stall_in_ready", 64'(bus_if.in_ready), 64'd0);
          prev_stall = 1'b1;
          prev_data  = bus_if.out_data;
          prev_idx   = bus_if.out_word_idx;
        end else begin
          prev_stall = 1'b0;
        end
        if (bus_if.out_valid && bus_if.out_ready) begin
          if (exp_q.size() == 0) begin
            check("spurious_out", 64'(bus_if.out_valid), 64'd0);
          end else begin
            exp_t e;
            e = exp_q.pop_front();
            check("out_data", 64'(bus_if.out_data), 64'(e.data));
            check("out_word_idx", 64'(bus_if.out_word_idx), 64'(e.idx));
            check("out_block_last", 64'(bus_if.out_block_last), 64'(e.idx == 4'd15));
            check("out_msg_last", 64'(bus_if.out_msg_last), 64'(e.last));
          end
        end
        if (bus_if.len_valid) begin
          if (len_q.size() == 0) check("spurious_len_valid", 64'(bus_if.len_valid), 64'd0);
          else                   check("len_o", bus_if.len_o, len_q.pop_front());
        end
      end
    end
  end

  initial begin
    bus_if.in_valid  = 1'b0;
    bus_if.in_data   = '0;
    bus_if.in_last   = 1'b0;
    bus_if.in_bytes  = '0;
    bus_if.out_ready = 1'b1;
    #1;
    check("rst_out_valid", 64'(bus_if.out_valid), 64'd0);
    check("rst_out_data", 64'(bus_if.out_data), 64'd0);
    check("rst_word_idx", 64'(bus_if.out_word_idx), 64'd0);
    check("rst_msg_last", 64'(bus_if.out_msg_last), 64'd0);
    check("rst_len_o", bus_if.len_o, 64'd0);
    check("rst_len_valid", 64'(bus_if.len_valid), 64'd0);
    check("rst_in_ready", 64'(bus_if.in_ready), 64'd0);
    repeat (3) @(negedge clk);
    rst    = 1'b0;
    mon_en = 1'b1;

    // "abc": single block, length 24
    msg = '{8'h61, 8'h62, 8'h63};
    send_msg(); drain();
    // 55 bytes: 0x80 lands in word 13, length directly follows
    rand_msg(55); send_msg(); drain();
    // 56 bytes: padding spills into a second block
    rand_msg(56); send_msg(); drain();
    // 56 bytes under random backpressure
    bp_en = 1'b1;
    rand_msg(56); send_msg(); drain();
    bp_en = 1'b0;

    // Reset after 5 words of a message: everything clears at once
    mon_en = 1'b0;
    for (int i = 0; i < 5; i++) send_word($urandom, 1'b0, 3'd4);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("mid_rst_out_valid", 64'(bus_if.out_valid), 64'd0);
    check("mid_rst_out_data", 64'(bus_if.out_data), 64'd0);
    check("mid_rst_word_idx", 64'(bus_if.out_word_idx), 64'd0);
    check("mid_rst_msg_last", 64'(bus_if.out_msg_last), 64'd0);
    check("mid_rst_len_o", bus_if.len_o, 64'd0);
    check("mid_rst_len_valid", 64'(bus_if.len_valid), 64'd0);
    check("mid_rst_in_ready", 64'(bus_if.in_ready), 64'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    exp_q.delete();
    len_q.delete();
    mon_en = 1'b1;
    msg = '{8'h61, 8'h62, 8'h63};
    send_msg(); drain();

    // Back-to-back: "abc" then 0xDEADBEEF
    msg = '{8'h61, 8'h62, 8'h63};
    send_msg();
    msg = '{8'hDE, 8'hAD, 8'hBE, 8'hEF};
    send_msg(); drain();

    // Random lengths with random backpressure
    bp_en = 1'b1;
    for (int m = 0; m < 20; m++) begin
      rand_msg($urandom_range(1, 140));
      send_msg(); drain();
    end
    bp_en = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
